hamm_dec_arb: RTL and testbench

HAMM_DEC_ARB -- requirements
Module: hamm_dec_arb

---
 rtl/hamm_dec_arb_if.sv | 26 ++
 rtl/hamm_dec_arb.sv | 109 ++++++++++
 tb/tb_hamm_dec_arb.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamm_dec_arb_if.sv
// Handshake bundle for the two-requester Hamming (7,4) decoder/arbiter.
interface hamm_dec_arb_if;
  logic       in0_valid;
  logic [7:1] in0_data;
  logic       in0_ready;
  logic       in1_valid;
  logic [7:1] in1_data;
  logic       in1_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [2:0] out_err_idx;
  logic       out_src;

  // Producer/consumer side (drives codewords, takes results)
  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_err_idx, out_src
  );

  // Decoder side
  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_err_idx, out_src
  );
endinterface

// File: rtl/hamm_dec_arb.sv
// Two-requester round-robin arbiter feeding a Hamming (7,4) single-error
// corrector with a one-entry output register and a saturating error counter.
module hamm_dec_arb #(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  hamm_dec_arb_if.slave     bus,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_data_q, out_data_d;
  logic [2:0]       out_err_idx_q, out_err_idx_d;
  logic             out_src_q, out_src_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             last_gnt_q, last_gnt_d;

  logic       slot_free_c;
  logic       gnt_c;
  logic       accept_c;
  logic       in0_ready_c;
  logic       in1_ready_c;
  logic [7:1] sel_cw_c;
  logic [2:0] syn_c;
  logic [7:0] flip_mask_c;
  logic [7:1] fixed_cw_c;

  // Arbitration, syndrome decode and next-state of all registers
  always_comb begin
    slot_free_c   = !out_valid_q || bus.out_ready;
    gnt_c         = 1'b0;
    accept_c      = 1'b0;
    in0_ready_c   = 1'b0;
    in1_ready_c   = 1'b0;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_err_idx_d = out_err_idx_q;
    out_src_d     = out_src_q;
    err_count_d   = err_count_q;
    last_gnt_d    = last_gnt_q;

    if (bus.in0_valid && bus.in1_valid) begin
      gnt_c = !last_gnt_q;
    end else begin
      gnt_c = bus.in1_valid;
    end

    // Ready is held low throughout reset, not just at the edge
    accept_c    = slot_free_c && (bus.in0_valid || bus.in1_valid) && !rst;
    in0_ready_c = accept_c && !gnt_c;
    in1_ready_c = accept_c && gnt_c;

    sel_cw_c = gnt_c ? bus.in1_data : bus.in0_data;
    syn_c[0] = sel_cw_c[1] ^ sel_cw_c[3] ^ sel_cw_c[5] ^ sel_cw_c[7];
    syn_c[1] = sel_cw_c[2] ^ sel_cw_c[3] ^ sel_cw_c[6] ^ sel_cw_c[7];
    syn_c[2] = sel_cw_c[4] ^ sel_cw_c[5] ^ sel_cw_c[6] ^ sel_cw_c[7];
    // Syndrome 0 lands on bit 0 of the mask, which is outside the codeword
    flip_mask_c = 8'(1) << syn_c;
    fixed_cw_c  = sel_cw_c ^ flip_mask_c[7:1];

    if (accept_c) begin
      out_valid_d   = 1'b1;
      out_data_d    = {fixed_cw_c[7], fixed_cw_c[6], fixed_cw_c[5], fixed_cw_c[3]};
      out_err_idx_d = syn_c;
      out_src_d     = gnt_c;
      last_gnt_d    = gnt_c;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (cnt_clr) begin
      err_count_d = '0;
    end else if (accept_c && (syn_c != 3'd0) && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
  end

  // Output register, error counter and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= 4'd0;
      out_err_idx_q <= 3'd0;
      out_src_q     <= 1'b0;
      err_count_q   <= '0;
      last_gnt_q    <= 1'b1;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_err_idx_q <= out_err_idx_d;
      out_src_q     <= out_src_d;
      err_count_q   <= err_count_d;
      last_gnt_q    <= last_gnt_d;
    end
  end

  assign bus.in0_ready   = in0_ready_c;
  assign bus.in1_ready   = in1_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_err_idx = out_err_idx_q;
  assign bus.out_src     = out_src_q;
  assign err_count       = err_count_q;

endmodule

// File: tb/tb_hamm_dec_arb.sv
// Self-checking bench for hamm_dec_arb: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_hamm_dec_arb;

  localparam int CNT_MAX = 255;

  logic       clk;
  logic       rst;
  logic       cnt_clr;
  logic [7:0] err_count;

  hamm_dec_arb_if bif ();

  hamm_dec_arb #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .cnt_clr   (cnt_clr),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic       m_valid;
  logic [3:0] m_data;
  logic [2:0] m_idx;
  logic       m_src;
  int         m_cnt;
  logic       m_last;

  logic exp_r0, exp_r1, obs_r0, obs_r1;

  // Syndrome of a Hamming code = XOR of the positions holding a one
  function automatic void ref_decode(input logic [7:1] cw, output logic [3:0] d,
                                     output logic [2:0] s);
    logic [7:1] fx;
    int         acc;
    acc = 0;
    for (int p = 1; p <= 7; p++) if (cw[p]) acc = acc ^ p;
    fx = cw;
    if (acc != 0) fx[acc] = ~fx[acc];
    d = {fx[7], fx[6], fx[5], fx[3]};
    s = 3'(acc);
  endfunction

  function automatic void model_reset();
    m_valid = 1'b0; m_data = 4'd0; m_idx = 3'd0; m_src = 1'b0;
    m_cnt = 0; m_last = 1'b1;
  endfunction

  // Drive one cycle of stimulus, sample readys, advance the model, clock.
  task automatic tick(input logic v0, input logic v1, input logic [7:1] d0,
                      input logic [7:1] d1, input logic ordy, input logic clr);
    logic       slot, g, acc;
    logic [3:0] d;
    logic [2:0] s;
    bif.in0_valid = v0; bif.in1_valid = v1;
    bif.in0_data  = d0; bif.in1_data  = d1;
    bif.out_ready = ordy; cnt_clr = clr;
    #1;
    obs_r0 = bif.in0_ready; obs_r1 = bif.in1_ready;
    slot = !m_valid || ordy;
    acc  = slot && (v0 || v1);
    g    = (v0 && v1) ? !m_last : v1;
    exp_r0 = acc && !g;
    exp_r1 = acc && g;
    ref_decode(g ? d1 : d0, d, s);
    if (clr) m_cnt = 0;
    else if (acc && s != 3'd0 && m_cnt < CNT_MAX) m_cnt++;
    if (acc) begin
      m_valid = 1'b1; m_data = d; m_idx = s; m_src = g; m_last = g;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.in0_valid = 1'b1; bif.in1_valid = 1'b1;
    bif.in0_data = 7'b1010101; bif.in1_data = 7'b1010101;
    bif.out_ready = 1'b1; cnt_clr = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bif.out_valid !== 1'b0 || bif.out_data !== 4'd0 || bif.out_err_idx !== 3'd0 ||
        bif.out_src !== 1'b0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%h i=%h s=%b c=%0d exp all zero",
               bif.out_valid, bif.out_data, bif.out_err_idx, bif.out_src, err_count);
    end
    total++;
    if (bif.in0_ready !== 1'b0 || bif.in1_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got r0=%b r1=%b exp 0 0", bif.in0_ready, bif.in1_ready);
    end
    bif.in0_valid = 1'b0; bif.in1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_clean();
    tick(1'b1, 1'b0, 7'b1010101, 7'd0, 1'b1, 1'b0);
    total++;
    if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin
      bad++;
      $display("FAIL clean_ready got r0=%b r1=%b exp 1 0", obs_r0, obs_r1);
    end
    total++;
    if (bif.out_valid !== 1'b1 || bif.out_data !== 4'b1011 || bif.out_err_idx !== 3'b000 ||
        bif.out_src !== 1'b0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL clean_word got v=%b d=%b i=%b s=%b c=%0d exp 1 1011 000 0 0",
               bif.out_valid, bif.out_data, bif.out_err_idx, bif.out_src, err_count);
    end
  endtask

  task automatic test_errors();
    tick(1'b0, 1'b1, 7'd0, 7'b1110101, 1'b1, 1'b0);
    total++;
    if (bif.out_data !== 4'b1011 || bif.out_err_idx !== 3'b110 || bif.out_src !== 1'b1 ||
        err_count !== 8'd1) begin
      bad++;
      $display("FAIL data_err got d=%b i=%b s=%b c=%0d exp 1011 110 1 1",
               bif.out_data, bif.out_err_idx, bif.out_src, err_count);
    end
    tick(1'b1, 1'b0, 7'b1011101, 7'd0, 1'b1, 1'b0);
    total++;
    if (bif.out_data !== 4'b1011 || bif.out_err_idx !== 3'b100 || bif.out_src !== 1'b0 ||
        err_count !== 8'd2) begin
      bad++;
      $display("FAIL parity_err got d=%b i=%b s=%b c=%0d exp 1011 100 0 2",
               bif.out_data, bif.out_err_idx, bif.out_src, err_count);
    end
    tick(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0);
    total++;
    if (bif.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty got v=%b exp 0", bif.out_valid);
    end
  endtask

  task automatic test_arbitration();
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b1, 7'b1010101, 7'b0110011, 1'b1, 1'b0);
      total++;
      if (bif.out_valid !== 1'b1 || bif.out_src !== 1'(k % 2)) begin
        bad++;
        $display("FAIL arb_alternate[%0d] got v=%b src=%b exp 1 %0d",
                 k, bif.out_valid, bif.out_src, k % 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] held_d;
    logic [2:0] held_i;
    logic       held_s;
    tick(1'b1, 1'b1, 7'b1110101, 7'b1011101, 1'b0, 1'b0);
    held_d = m_data; held_i = m_idx; held_s = m_src;
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b1, 7'($urandom), 7'($urandom), 1'b0, 1'b0);
      total++;
      if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0 || bif.out_valid !== 1'b1 ||
          bif.out_data !== held_d || bif.out_err_idx !== held_i || bif.out_src !== held_s) begin
        bad++;
        $display("FAIL stall[%0d] got r=%b%b v=%b d=%h i=%h s=%b exp r=00 v=1 d=%h i=%h s=%b",
                 k, obs_r0, obs_r1, bif.out_valid, bif.out_data, bif.out_err_idx,
                 bif.out_src, held_d, held_i, held_s);
      end
    end
    tick(1'b1, 1'b1, 7'b1010101, 7'b1110101, 1'b1, 1'b0);
    total++;
    if (obs_r0 !== exp_r0 || obs_r1 !== exp_r1 || (obs_r0 | obs_r1) !== 1'b1 ||
        bif.out_valid !== 1'b1 || bif.out_src !== m_src || bif.out_data !== m_data ||
        bif.out_err_idx !== m_idx) begin
      bad++;
      $display("FAIL drain_accept got r=%b%b v=%b d=%h i=%h s=%b exp r=%b%b v=1 d=%h i=%h s=%b",
               obs_r0, obs_r1, bif.out_valid, bif.out_data, bif.out_err_idx, bif.out_src,
               exp_r0, exp_r1, m_data, m_idx, m_src);
    end
  endtask

  task automatic test_saturation();
    tick(1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b1);
    total++;
    if (err_count !== 8'd0) begin
      bad++;
      $display("FAIL cnt_clear got %0d exp 0", err_count);
    end
    for (int k = 1; k <= 256; k++) begin
      tick(1'b1, 1'b0, 7'b1110101, 7'd0, 1'b1, 1'b0);
      if (k == 254 || k == 255 || k == 256) begin
        total++;
        if (err_count !== 8'((k > 255) ? 255 : k)) begin
          bad++;
          $display("FAIL cnt_sat[%0d] got %0d exp %0d", k, err_count, (k > 255) ? 255 : k);
        end
      end
    end
    tick(1'b1, 1'b0, 7'b1110101, 7'd0, 1'b1, 1'b1);
    total++;
    if (err_count !== 8'd0 || bif.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL cnt_clr_priority got c=%0d v=%b exp 0 1", err_count, bif.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 7'b1110101, 7'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bif.out_valid !== 1'b0 || err_count !== 8'd0) begin
      bad++;
      $display("FAIL async_reset got v=%b c=%0d exp 0 0", bif.out_valid, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick(1'b1, 1'b1, 7'b1010101, 7'b1110101, 1'b1, 1'b0);
    total++;
    if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0 || bif.out_src !== 1'b0 || bif.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_grant got r=%b%b src=%b v=%b exp r=10 src=0 v=1",
               obs_r0, obs_r1, bif.out_src, bif.out_valid);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick(1'($urandom), 1'($urandom), 7'($urandom), 7'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
      total++;
      if (obs_r0 !== exp_r0 || obs_r1 !== exp_r1 || bif.out_valid !== m_valid ||
          bif.out_data !== m_data || bif.out_err_idx !== m_idx || bif.out_src !== m_src ||
          err_count !== 8'(m_cnt)) begin
        bad++;
        $display("FAIL random[%0d] got r=%b%b v=%b d=%h i=%h s=%b c=%0d exp r=%b%b v=%b d=%h i=%h s=%b c=%0d",
                 k, obs_r0, obs_r1, bif.out_valid, bif.out_data, bif.out_err_idx, bif.out_src,
                 err_count, exp_r0, exp_r1, m_valid, m_data, m_idx, m_src, m_cnt);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean();
    test_errors();
    test_arbitration();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
